register_writeback_queue: RTL and testbench

- Producer side of the register file write port: collects results from the ALU path and the load path and serialises them onto the single register write port (register_write / write_register / write_data).
- Buffers results in a small in-order FIFO with valid/ready backpressure toward both producers.
- Exports a pending-destination mask so decode can detect hazards against writes that are still queued.

---
 rtl/register_writeback_queue_if.sv | 37 +++
 rtl/register_writeback_queue.sv | 148 ++++++++++++++
 tb/tb_register_writeback_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_writeback_queue_if.sv
// Handshake and write-port bundle for register_writeback_queue.
// slave: the queue side. master: the producer / register-file side.
interface register_writeback_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                          alu_valid;
    logic                          alu_ready;
    logic [ADDR_WIDTH-1:0]         alu_register;
    logic [DATA_WIDTH-1:0]         alu_data;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADDR_WIDTH-1:0]         mem_register;
    logic [DATA_WIDTH-1:0]         mem_data;
    logic                          register_write;
    logic [ADDR_WIDTH-1:0]         write_register;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [2**ADDR_WIDTH-1:0]      pending_mask;
    logic [$clog2(DEPTH):0]        queue_count;

    modport slave (
        input  alu_valid, alu_register, alu_data,
        input  mem_valid, mem_register, mem_data,
        output alu_ready, mem_ready,
        output register_write, write_register, write_data,
        output pending_mask, queue_count
    );

    modport master (
        output alu_valid, alu_register, alu_data,
        output mem_valid, mem_register, mem_data,
        input  alu_ready, mem_ready,
        input  register_write, write_register, write_data,
        input  pending_mask, queue_count
    );
endinterface

// File: rtl/register_writeback_queue.sv
// Register writeback queue: merges ALU and load results into an in-order FIFO and
// drains it onto the single register-file write port, one write per cycle.
// Optional macro WB_BYPASS_EN: when the queue is empty, the first accepted entry goes
// straight to the output registers (latency 1 instead of 2).
module register_writeback_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    register_writeback_queue_if.slave     bus
);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] reg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  wr_strobe;
    logic [ADDR_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [CNT_WIDTH-1:0]  free;
    logic                  mem_ready;
    logic                  alu_ready;
    logic                  mem_keep;
    logic                  alu_keep;
    logic                  deq;
    logic                  bypass;

    logic                  first_valid;
    logic [ADDR_WIDTH-1:0] first_reg;
    logic [DATA_WIDTH-1:0] first_data;
    logic                  both_keep;

    logic                  qa_valid;
    logic [ADDR_WIDTH-1:0] qa_reg;
    logic [DATA_WIDTH-1:0] qa_data;
    logic                  qb_valid;
    logic [1:0]            n_enq;

    logic [PTR_WIDTH-1:0]     slot_off;
    logic [2**ADDR_WIDTH-1:0] mask;

    // Readiness from occupancy at the start of the cycle; a same-cycle dequeue adds no space.
    always_comb begin
        free      = CNT_WIDTH'(DEPTH) - count;
        mem_ready = (free != '0);
        alu_ready = (free >= CNT_WIDTH'(2)) || ((free != '0) && !bus.mem_valid);
        // x0 writes handshake normally but are dropped here.
        mem_keep  = bus.mem_valid && mem_ready && (bus.mem_register != '0);
        alu_keep  = bus.alu_valid && alu_ready && (bus.alu_register != '0);
        deq       = (count != '0);
        both_keep = mem_keep && alu_keep;
    end

    // Order the accepted entries (load first) and split them between bypass and queue.
    always_comb begin
        first_valid = mem_keep || alu_keep;
        first_reg   = mem_keep ? bus.mem_register : bus.alu_register;
        first_data  = mem_keep ? bus.mem_data     : bus.alu_data;
`ifdef WB_BYPASS_EN
        bypass      = (count == '0) && first_valid;
`else
        bypass      = 1'b0;
`endif
        if (bypass) begin
            // First entry goes to the output; only a second (ALU) entry is queued.
            qa_valid = both_keep;
            qa_reg   = bus.alu_register;
            qa_data  = bus.alu_data;
            qb_valid = 1'b0;
        end else begin
            qa_valid = first_valid;
            qa_reg   = first_reg;
            qa_data  = first_data;
            qb_valid = both_keep;
        end
        n_enq = {1'b0, qa_valid} + {1'b0, qb_valid};
    end

    // Queue storage; the ALU entry of a double enqueue lands one slot after the load.
    always_ff @(posedge clock) begin
        if (qa_valid) begin
            reg_mem[wr_ptr]  <= qa_reg;
            data_mem[wr_ptr] <= qa_data;
        end
        if (qb_valid) begin
            reg_mem[wr_ptr + PTR_WIDTH'(1)]  <= bus.alu_register;
            data_mem[wr_ptr + PTR_WIDTH'(1)] <= bus.alu_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wr_strobe <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(n_enq);
            count  <= count + CNT_WIDTH'(n_enq) - CNT_WIDTH'(deq);
            if (deq) begin
                rd_ptr    <= rd_ptr + PTR_WIDTH'(1);
                wr_strobe <= 1'b1;
                wr_reg    <= reg_mem[rd_ptr];
                wr_data   <= data_mem[rd_ptr];
            end else if (bypass) begin
                wr_strobe <= 1'b1;
                wr_reg    <= first_reg;
                wr_data   <= first_data;
            end else begin
                wr_strobe <= 1'b0;
            end
        end
    end

    // Pending destinations: every occupied slot plus the write being presented.
    always_comb begin
        mask     = '0;
        slot_off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_off = PTR_WIDTH'(i) - rd_ptr;
            if ({1'b0, slot_off} < count) begin
                mask[reg_mem[i]] = 1'b1;
            end
        end
        if (wr_strobe) begin
            mask[wr_reg] = 1'b1;
        end
        mask[0] = 1'b0;
    end

    assign bus.alu_ready      = alu_ready;
    assign bus.mem_ready      = mem_ready;
    assign bus.register_write = wr_strobe;
    assign bus.write_register = wr_reg;
    assign bus.write_data     = wr_data;
    assign bus.pending_mask   = mask;
    assign bus.queue_count    = count;
endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed testbench for register_writeback_queue (DEPTH=4, 5-bit index, 32-bit data).
module tb_register_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
    int exp_aready [6] = '{1, 1, 1, 0, 1, 1};
    int exp_count  [6] = '{1, 2, 3, 3, 3, 3};
`else
    localparam int LAT = 2;
    int exp_aready [6] = '{1, 1, 0, 0, 1, 1};
    int exp_count  [6] = '{2, 3, 3, 3, 3, 3};
`endif

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    logic [AW+DW-1:0] log_q [$];
    int               log_cyc [$];
    logic [AW+DW-1:0] exp_q [$];

    register_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    register_writeback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Strobe log, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.register_write === 1'b1) begin
            log_q.push_back({bus.write_register, bus.write_data});
            log_cyc.push_back(cyc_n);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0;
        bus.alu_register = '0;
        bus.alu_data     = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_register = '0;
        bus.mem_data     = '0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.alu_valid    = 1'b1;
        bus.alu_register = 5'd3;
        bus.alu_data     = 32'h1234_5678;
        bus.mem_valid    = 1'b1;
        bus.mem_register = 5'd4;
        bus.mem_data     = 32'h8765_4321;
        tick();
        tick();
        n_vec++; if (bus.register_write !== 1'b0) begin n_err++;
            $display("FAIL reset_register_write got %b want 0", bus.register_write); end
        n_vec++; if (bus.write_register !== 5'd0) begin n_err++;
            $display("FAIL reset_write_register got %0d want 0", bus.write_register); end
        n_vec++; if (bus.write_data !== 32'd0) begin n_err++;
            $display("FAIL reset_write_data got %h want 0", bus.write_data); end
        n_vec++; if (bus.queue_count !== 3'd0) begin n_err++;
            $display("FAIL reset_queue_count got %0d want 0", bus.queue_count); end
        n_vec++; if (bus.pending_mask !== 32'd0) begin n_err++;
            $display("FAIL reset_pending_mask got %h want 0", bus.pending_mask); end
        reset = 1'b0;
        idle_inputs();
        #1;
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
        n_vec++; if (bus.mem_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_mem_ready got %b want 1", bus.mem_ready); end
        tick();
    endtask

    task automatic test_single_alu();
        log_q.delete();
        log_cyc.delete();
        bus.alu_valid    = 1'b1;
        bus.alu_register = 5'd5;
        bus.alu_data     = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++;
            $display("FAIL single_alu_ready got %b want 1", bus.alu_ready); end
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            n_vec++; if (bus.register_write !== ((c == LAT) ? 1'b1 : 1'b0)) begin n_err++;
                $display("FAIL single_strobe c%0d got %b want %b", c, bus.register_write,
                         (c == LAT)); end
            n_vec++; if (bus.pending_mask !== ((c <= LAT) ? 32'h20 : 32'h0)) begin n_err++;
                $display("FAIL single_mask c%0d got %h want %h", c, bus.pending_mask,
                         (c <= LAT) ? 32'h20 : 32'h0); end
            n_vec++; if (bus.queue_count !== ((c < LAT) ? 3'd1 : 3'd0)) begin n_err++;
                $display("FAIL single_count c%0d got %0d want %0d", c, bus.queue_count,
                         (c < LAT) ? 1 : 0); end
            if (c >= LAT) begin
                n_vec++; if (bus.write_register !== 5'd5) begin n_err++;
                    $display("FAIL single_wreg c%0d got %0d want 5", c, bus.write_register); end
                n_vec++; if (bus.write_data !== 32'hDEAD_BEEF) begin n_err++;
                    $display("FAIL single_wdata c%0d got %h want deadbeef", c, bus.write_data); end
            end
        end
    endtask

    task automatic test_same_register();
        log_q.delete();
        log_cyc.delete();
        bus.mem_valid    = 1'b1;
        bus.mem_register = 5'd7;
        bus.mem_data     = 32'h11;
        bus.alu_valid    = 1'b1;
        bus.alu_register = 5'd7;
        bus.alu_data     = 32'h22;
        #1;
        n_vec++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin n_err++;
            $display("FAIL same_ready got mem=%b alu=%b want 1 1", bus.mem_ready, bus.alu_ready); end
        tick();
        idle_inputs();
        n_vec++; if (bus.pending_mask !== 32'h80) begin n_err++;
            $display("FAIL same_mask got %h want 80", bus.pending_mask); end
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (log_q.size() != 2) begin n_err++;
            $display("FAIL same_strobes got %0d want 2", log_q.size()); end
        if (log_q.size() == 2) begin
            n_vec++; if (log_q[0] !== {5'd7, 32'h11}) begin n_err++;
                $display("FAIL same_first got %h want %h", log_q[0], {5'd7, 32'h11}); end
            n_vec++; if (log_q[1] !== {5'd7, 32'h22}) begin n_err++;
                $display("FAIL same_second got %h want %h", log_q[1], {5'd7, 32'h22}); end
            n_vec++; if (log_cyc[1] != log_cyc[0] + 1) begin n_err++;
                $display("FAIL same_consecutive got cycles %0d,%0d want adjacent",
                         log_cyc[0], log_cyc[1]); end
        end
    endtask

    task automatic test_backpressure();
        int aidx;
        int max_count;
        aidx      = 0;
        max_count = 0;
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            bus.mem_valid    = (c < 4);
            bus.mem_register = 5'(1 + c);
            bus.mem_data     = 32'(32'h100 + c);
            bus.alu_valid    = 1'b1;
            bus.alu_register = 5'(10 + aidx);
            bus.alu_data     = 32'(32'h200 + aidx);
            #1;
            n_vec++; if (bus.mem_ready !== 1'b1) begin n_err++;
                $display("FAIL bp_mem_ready c%0d got %b want 1", c, bus.mem_ready); end
            n_vec++; if (bus.alu_ready !== 1'(exp_aready[c])) begin n_err++;
                $display("FAIL bp_alu_ready c%0d got %b want %0d", c, bus.alu_ready,
                         exp_aready[c]); end
            if (c < 4) exp_q.push_back({5'(1 + c), 32'(32'h100 + c)});
            if (exp_aready[c] != 0) begin
                exp_q.push_back({5'(10 + aidx), 32'(32'h200 + aidx)});
                aidx++;
            end
            tick();
            n_vec++; if (bus.queue_count !== 3'(exp_count[c])) begin n_err++;
                $display("FAIL bp_count c%0d got %0d want %0d", c, bus.queue_count,
                         exp_count[c]); end
            if (int'(bus.queue_count) > max_count) max_count = int'(bus.queue_count);
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int'(bus.queue_count) > max_count) max_count = int'(bus.queue_count);
        end
        n_vec++; if (max_count > DEPTH) begin n_err++;
            $display("FAIL bp_max_count got %0d want <= %0d", max_count, DEPTH); end
        n_vec++; if (bus.queue_count !== 3'd0) begin n_err++;
            $display("FAIL bp_drained got %0d want 0", bus.queue_count); end
        n_vec++; if (log_q.size() != exp_q.size()) begin n_err++;
            $display("FAIL bp_strobes got %0d want %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) begin
                n_vec++; if (log_q[i] !== exp_q[i]) begin n_err++;
                    $display("FAIL bp_order[%0d] got %h want %h", i, log_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_x0();
        log_q.delete();
        log_cyc.delete();
        bus.alu_valid    = 1'b1;
        bus.alu_register = 5'd0;
        bus.alu_data     = 32'h55;
        #1;
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++;
            $display("FAIL x0_ready got %b want 1", bus.alu_ready); end
        tick();
        idle_inputs();
        n_vec++; if (bus.queue_count !== 3'd0) begin n_err++;
            $display("FAIL x0_count got %0d want 0", bus.queue_count); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (bus.register_write !== 1'b0 || bus.pending_mask !== 32'd0) begin n_err++;
                $display("FAIL x0_quiet c%0d got strobe=%b mask=%h want 0 0", i,
                         bus.register_write, bus.pending_mask); end
            tick();
        end
        n_vec++; if (log_q.size() != 0) begin n_err++;
            $display("FAIL x0_strobes got %0d want 0", log_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            bus.mem_valid    = 1'b1;
            bus.mem_register = 5'(20 + 2 * c);
            bus.mem_data     = 32'(32'hA0 + 2 * c);
            bus.alu_valid    = 1'b1;
            bus.alu_register = 5'(21 + 2 * c);
            bus.alu_data     = 32'(32'hA1 + 2 * c);
            tick();
        end
        idle_inputs();
        n_vec++; if (bus.queue_count !== 3'd3) begin n_err++;
            $display("FAIL mid_prefill got %0d want 3", bus.queue_count); end
        reset = 1'b1;
        tick();
        log_q.delete();
        log_cyc.delete();
        n_vec++; if (bus.queue_count !== 3'd0) begin n_err++;
            $display("FAIL mid_count got %0d want 0", bus.queue_count); end
        n_vec++; if (bus.register_write !== 1'b0) begin n_err++;
            $display("FAIL mid_strobe got %b want 0", bus.register_write); end
        n_vec++; if (bus.pending_mask !== 32'd0) begin n_err++;
            $display("FAIL mid_mask got %h want 0", bus.pending_mask); end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++; if (log_q.size() != 0) begin n_err++;
            $display("FAIL mid_flushed got %0d strobes want 0", log_q.size()); end
        n_vec++; if (bus.queue_count !== 3'd0) begin n_err++;
            $display("FAIL mid_after got %0d want 0", bus.queue_count); end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_same_register();
        test_backpressure();
        test_x0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
